// File: rtl/sipo_rx_pkg.sv
// rtl/sipo_rx_pkg.sv - shared types and helpers for the sipo_rx serial receiver
// Contents: shift-side state encoding, frame length, even-parity reduction.
// Optional feature macro: SIPO_RX_PARITY_EN (adds one parity bit per frame).
package sipo_rx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_t;

    // Qualified bits per frame: data bits, plus the trailing parity bit when enabled.
    function automatic int frame_len(input int width);
`ifdef SIPO_RX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // 1 when the frame (data + parity) holds an odd number of ones.
    function automatic logic parity_odd(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/sipo_word_buf.sv
// rtl/sipo_word_buf.sv - single-entry holding register with valid/ready and overflow
// Ports: clk, rst (sync, active-low), load/load_data (completed word),
//        load_perr/parity_err (only with SIPO_RX_PARITY_EN), dout_ready,
//        ovf_clr, dout, dout_valid, overflow.
module sipo_word_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef SIPO_RX_PARITY_EN
    input  logic             load_perr,
    output logic             parity_err,
`endif
    input  logic             dout_ready,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overflow
);

    // A new word may land when the entry is empty or is being drained this edge.
    logic can_load;
    logic drop;

    assign can_load = !dout_valid || dout_ready;
    assign drop     = load && !can_load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (load && can_load) begin
            dout       <= load_data;
            dout_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= load_perr;
`endif
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Set wins over clear so a drop on the clearing edge is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in parallel-out receiver, MSB first, valid/ready word output
// Ports: clk, rst (sync, active-low), sin_valid/sin (serial input), clr (resync),
//        dout/dout_valid/dout_ready (word handshake), busy, overflow, ovf_clr,
//        parity_err (only with SIPO_RX_PARITY_EN).
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow,
`ifdef SIPO_RX_PARITY_EN
    output logic             parity_err,
`endif
    input  logic             ovf_clr
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = $clog2(FRAME + 1);
    // The last bit of a frame is taken straight from sin, so only FRAME-1 bits are stored.
    localparam int SH_W  = FRAME - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    sipo_state_t      state;
    logic [SH_W-1:0]  shreg, shreg_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [SH_W:0]    frame_bits;
    logic             complete;
    logic [WIDTH-1:0] word;

    assign frame_bits = {shreg, sin};

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    always_comb begin
        state     = (bit_cnt == '0) ? ST_IDLE : ST_SHIFT;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        complete  = 1'b0;
        if (clr) begin
            shreg_n   = '0;
            bit_cnt_n = '0;
        end else if (sin_valid) begin
            shreg_n = frame_bits[SH_W-1:0];
            unique case (state)
                ST_IDLE: bit_cnt_n = CNT_W'(1);
                ST_SHIFT: begin
                    if (bit_cnt == LAST) begin
                        complete  = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
                default: bit_cnt_n = '0;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);

`ifdef SIPO_RX_PARITY_EN
    logic word_perr;

    // Data bits are all in shreg; sin carries the parity bit on the completion edge.
    assign word      = shreg;
    assign word_perr = parity_odd(64'(frame_bits));
`else
    assign word = frame_bits;
`endif

    sipo_word_buf #(
        .WIDTH(WIDTH)
    ) u_word_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .load_data  (word),
`ifdef SIPO_RX_PARITY_EN
        .load_perr  (word_perr),
        .parity_err (parity_err),
`endif
        .dout_ready (dout_ready),
        .ovf_clr    (ovf_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - self-checking bench for sipo_rx (default build, WIDTH=4)
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin = 1'b0;
    logic         clr = 1'b0;
    logic         dout_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         overflow;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current frame, and the one-word holding slot.
    bit           mq[$];
    logic [W-1:0] m_dout  = '0;
    bit           m_valid = 1'b0;
    bit           m_ovf   = 1'b0;
    bit           check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit sv, input bit s, input bit c,
                         input bit rdy, input bit oc);
        bit           done;
        bit           ovf_set;
        logic [W-1:0] w;
        done    = 1'b0;
        ovf_set = 1'b0;
        w       = '0;
        if (!r) begin
            mq.delete();
            m_valid = 1'b0;
            m_dout  = '0;
            m_ovf   = 1'b0;
        end else begin
            if (c) begin
                mq.delete();
            end else if (sv) begin
                mq.push_back(s);
                if (mq.size() == W) begin
                    for (int i = 0; i < W; i++) w = W'(w * 2 + W'(mq[i]));
                    mq.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_dout  = w;
                    m_valid = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, return at negedge.
    task automatic step(input bit r, input bit sv, input bit s, input bit c,
                        input bit rdy, input bit oc);
        rst = r; sin_valid = sv; sin = s; clr = c; dout_ready = rdy; ovf_clr = oc;
        @(posedge clk);
        model(r, sv, s, c, rdy, oc);
        @(negedge clk);
    endtask

    task automatic bit_in(input bit s, input bit rdy);
        step(1'b1, 1'b1, s, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(mq.size() != 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (m_valid) chk("dout", 32'(dout), 32'(m_dout));
        end
    end

    initial begin
        int nv;
        check_en = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_flags", 32'({dout_valid, busy, overflow}), 32'(0));

        // 1,0,1,1 back-to-back
        bit_in(1'b1, 1'b0);
        chk("t1_busy_after_b1", 32'(busy), 32'(1));
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("t1_busy_after_b3", 32'(busy), 32'(1));
        bit_in(1'b1, 1'b0);
        chk("t1_dout", 32'(dout), 32'(4'b1011));
        chk("t1_valid", 32'(dout_valid), 32'(1));
        chk("t1_busy_done", 32'(busy), 32'(0));
        idle(1'b1);
        chk("t1_drained", 32'(dout_valid), 32'(0));

        // 1,1,0,1 with 3-cycle gaps, always ready
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            bit_in((i == 2) ? 1'b0 : 1'b1, 1'b1);
            if (dout_valid) begin
                nv++;
                chk("t2_dout", 32'(dout), 32'(4'b1101));
            end
            for (int g = 0; g < 3; g++) begin
                idle(1'b1);
                if (dout_valid) nv++;
            end
        end
        chk("t2_valid_cycles", 32'(nv), 32'(1));

        // Backpressure: 0011 held, 1100 dropped
        for (int i = 0; i < 4; i++) bit_in((i >= 2) ? 1'b1 : 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bit_in((i < 2) ? 1'b1 : 1'b0, 1'b0);
        chk("t3_dout_held", 32'(dout), 32'(4'b0011));
        chk("t3_overflow", 32'(overflow), 32'(1));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovf_clr", 32'(overflow), 32'(0));
        idle(1'b1);

        // Back-to-back 1010,0101 with ready high
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
        chk("t4_w1", 32'(dout), 32'(4'b1010));
        bit_in(1'b0, 1'b1);
        chk("t4_w1_gone", 32'(dout_valid), 32'(0));
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        chk("t4_w2", 32'(dout), 32'(4'b0101));
        chk("t4_no_ovf", 32'(overflow), 32'(0));
        idle(1'b1);

        // Accept lands on the completion edge of the second word
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0);
        chk("t4b_hold", 32'(dout), 32'(4'b1010));
        bit_in(1'b1, 1'b1);
        chk("t4b_valid_stays", 32'(dout_valid), 32'(1));
        chk("t4b_new_word", 32'(dout), 32'(4'b0101));
        chk("t4b_no_ovf", 32'(overflow), 32'(0));
        idle(1'b1);

        // clr discards partial word; sin on the clr edge is ignored
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_clr_busy", 32'(busy), 32'(0));
        bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
        chk("t5_dout", 32'(dout), 32'(4'b0110));

        // Reset mid-word
        bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_rst_all", 32'({dout, dout_valid, busy, overflow}), 32'(0));
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        chk("t5_after_rst", 32'(dout), 32'(4'b1001));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 19) == 0));
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in, parallel-out receiver; the receive end of the team's 4-bit PISO serial link.
- Samples one bit per qualified clock, MSB first, and assembles WIDTH-bit words.
- Each completed word goes into a holding register and is presented on a valid/ready parallel interface.
- Flags words dropped under backpressure; supports mid-word resynchronisation.

Parameters:
- WIDTH, 4, data bits per word (>= 2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (0 = reset)
- sin_valid  input  1  qualifies sin this cycle
- sin  input  1  serial data bit, MSB of word first
- clr  input  1  synchronous frame resync; discards partial word
- dout  output  WIDTH  assembled word (holding register)
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- busy  output  1  partial word in progress (bit_cnt != 0)
- overflow  output  1  sticky; a completed word was dropped
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (rst==0 at posedge): shift register=0, bit_cnt=0, dout=0, dout_valid=0, busy=0, overflow=0. Reset overrides all other inputs, including mid-word.
- Shift side, two states:
  - IDLE (bit_cnt==0).
  - SHIFT (0<bit_cnt<WIDTH).
- On each posedge with sin_valid=1: shreg <= {shreg[WIDTH-2:0], sin}; bit_cnt++. Cycles with sin_valid=0 hold all shift state (gaps allowed anywhere).
- Word completion: the edge where sin_valid=1 and bit_cnt==WIDTH-1.
  - Word = {shreg[WIDTH-2:0], sin}.
  - bit_cnt returns to 0 on the same edge; back-to-back words need no idle cycle.
- Latency: dout/dout_valid update on the completion edge, so they are visible one cycle after the last bit is presented.
- Output handshake: the transfer occurs on a posedge with dout_valid=1 and dout_ready=1. dout holds stable while dout_valid=1 and dout_ready=0.
- Holding-register update on a completion edge:
  - Holding empty, or accepted this same edge: load the new word; dout_valid=1. Simultaneous accept+complete leaves dout_valid high with the new word.
  - Holding full and not accepted: new word dropped, dout unchanged, overflow <= 1.
- On a transfer edge with no completion: dout_valid <= 0; dout keeps its last value.
- clr=1 (with rst=1): bit_cnt <= 0 and shreg <= 0; any sin on that edge is ignored. The holding register and dout_valid are unaffected. clr has priority over shifting.
- overflow: sticky until ovf_clr=1 or reset. If ovf_clr and a new overflow occur on the same edge, overflow stays 1 (set wins).
- busy = (bit_cnt != 0), registered-equivalent (derived from the counter).
- dout_ready while dout_valid=0 has no effect.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- When defined:
  - One extra bit follows the WIDTH data bits (frame = WIDTH+1 qualified bits); even parity over data+parity.
  - Completion occurs at bit_cnt==WIDTH.
  - Adds output parity_err (1 bit). It loads alongside dout and is valid while dout_valid=1; 1 means the XOR of all WIDTH+1 bits was 1.
  - parity_err resets to 0. A word with a parity error is still delivered.
  - CNT_W covers WIDTH+1.
- When undefined: no parity bit, no parity_err port, behaviour exactly as above.

Decomposition:
- Package sipo_rx_pkg:
  - state encoding localparams ST_IDLE/ST_SHIFT;
  - function computing the frame length (WIDTH or WIDTH+1 under the macro);
  - even-parity reduction function.
- One natural sub-module: sipo_word_buf. It is the single-entry holding register with valid/ready, load request, drop/overflow generation and the parity_err field. The top holds the shifter, counter and clr/reset logic.

Test Plan:
- Reset then sin_valid=1 with sin=1,0,1,1 on four consecutive cycles -> dout=4'b1011, dout_valid=1 the cycle after the 4th bit; busy=1 during bits 2-4, 0 after.
- Bits 1,1,0,1 with sin_valid=0 gaps of 3 cycles between each, dout_ready=1 -> dout=4'b1101 valid for exactly one cycle; no extra words.
- dout_ready=0 held; send 4'b0011 then 4'b1100 -> dout stays 4'b0011, overflow=1; pulse ovf_clr -> overflow=0.
- dout_ready=1 throughout; send 4'b1010 then 4'b0101 back-to-back (8 consecutive bits) -> dout_valid high 1 cycle per word, dout=1010 then 0101, overflow=0. Repeat with the accept landing on the completion edge -> dout_valid stays 1 across the word change.
- Send 1,1 then clr=1, then 0,1,1,0 -> dout=4'b0110. Separately, drive rst=0 after 2 bits, then send 1,0,0,1 -> dout=4'b1001 and all outputs 0 during reset.
- With SIPO_RX_PARITY_EN: send 1,0,1,1 then parity 1 -> dout=4'b1011, parity_err=0. Send 1,0,1,1 then parity 0 -> parity_err=1 with dout_valid=1.
